// File: rtl/add16_arbiter.sv
// Round-robin front end for one shared combinational adder. Each grant latches
// one operand pair, runs it through the adder for one cycle, and returns the sum.
module add16_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*WIDTH-1:0] i_req_a,
    input  logic [N_REQ*WIDTH-1:0] i_req_b,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic [WIDTH-1:0]       o_add_a,
    output logic [WIDTH-1:0]       o_add_b,
    input  logic [WIDTH-1:0]       i_add_sum,
    output logic                   o_rsp_valid,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic [WIDTH-1:0]       o_rsp_sum,
    input  logic                   i_rsp_ready,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    int              rr_idx;

    // Search rr_ptr, rr_ptr+1, ... mod N_REQ; the first valid requester wins.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path through
        // the block leaves one unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_id    = '0;
        rr_idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_idx = (int'(rr_ptr_q) + i) % N_REQ;
            if (!grant_found && i_req_valid[ID_W'(rr_idx)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        o_req_ready = '0;
        o_add_a     = '0;
        o_add_b     = '0;
        o_rsp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A grant is always a handshake: the granted requester is valid.
                if (grant_found) begin
                    o_req_ready[grant_id] = 1'b1;
                    a_d     = i_req_a[int'(grant_id)*WIDTH +: WIDTH];
                    b_d     = i_req_b[int'(grant_id)*WIDTH +: WIDTH];
                    id_d    = grant_id;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_add_a = a_q;
                o_add_b = b_q;
                sum_d   = i_add_sum;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                // Pointer moves only once the response is consumed.
                if (i_rsp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
        end
    end

    assign o_rsp_id  = id_q;
    assign o_rsp_sum = sum_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_add16_arbiter.sv
// Directed bench for add16_arbiter: the bench supplies the shared adder and
// checks grants, latency, wrap, round-robin order, backpressure and reset.
module tb_add16_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_sum;
    logic           rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_ready;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    assign add_sum = add_a + add_b;

    add16_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .i_add_sum   (add_sum),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .i_rsp_ready (rsp_ready),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction from requester k with rsp_ready held high.
    task automatic run_one(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] sum, output logic [IW-1:0] id, output bit ok);
        bit acc;
        bit got;
        acc = 1'b0;
        got = 1'b0;
        sum = '1;
        id  = '0;
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
        req_valid[k]    = 1'b1;
        rsp_ready       = 1'b1;
        for (int n = 0; n < 10 && !acc; n++) begin
            @(negedge clk);
            if (req_ready[k]) acc = 1'b1;
            step();
        end
        req_valid[k] = 1'b0;
        for (int n = 0; n < 10 && acc && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                sum = rsp_sum;
                id  = rsp_id;
            end
            step();
        end
        ok = acc && got;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (add_a !== 16'h0) begin failures++; $display("FAIL reset_add_a got=%h exp=0000", add_a); end
        checks++; if (add_b !== 16'h0) begin failures++; $display("FAIL reset_add_b got=%h exp=0000", add_b); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_sum !== 16'h0) begin failures++; $display("FAIL reset_rsp_sum got=%h exp=0000", rsp_sum); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_a[15:0] = 16'h1234; req_b[15:0] = 16'h0101; req_valid = 4'b0001; rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready_c0 got=%b exp=0001", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_c0 got=%b exp=0", busy); end
        step();
        req_valid = '0; req_a[15:0] = 16'hDEAD; req_b[15:0] = 16'hBEEF;
        @(negedge clk);
        checks++; if (add_a !== 16'h1234) begin failures++; $display("FAIL single_add_a_c1 got=%h exp=1234", add_a); end
        checks++; if (add_b !== 16'h0101) begin failures++; $display("FAIL single_add_b_c1 got=%h exp=0101", add_b); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_c1 got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_valid_c1 got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_c1 got=%b exp=1", busy); end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid_c2 got=%b exp=1", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp_id_c2 got=%0d exp=0", rsp_id); end
        checks++; if (rsp_sum !== 16'h1335) begin failures++; $display("FAIL single_rsp_sum_c2 got=%h exp=1335", rsp_sum); end
        checks++; if (add_a !== 16'h0) begin failures++; $display("FAIL single_add_a_c2 got=%h exp=0000", add_a); end
        step();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_c3 got=%b exp=0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_valid_c3 got=%b exp=0", rsp_valid); end
        step();
    endtask

    task automatic test_wrap();
        logic [W-1:0]  s;
        logic [IW-1:0] id;
        bit            ok;
        run_one(1, 16'hFFFF, 16'h0001, s, id, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap1_timeout got=no_response exp=response"); end
        checks++; if (s !== 16'h0000) begin failures++; $display("FAIL wrap1_sum got=%h exp=0000", s); end
        checks++; if (id !== 2'd1) begin failures++; $display("FAIL wrap1_id got=%0d exp=1", id); end
        run_one(2, 16'h8000, 16'h8000, s, id, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap2_timeout got=no_response exp=response"); end
        checks++; if (s !== 16'h0000) begin failures++; $display("FAIL wrap2_sum got=%h exp=0000", s); end
        checks++; if (id !== 2'd2) begin failures++; $display("FAIL wrap2_id got=%0d exp=2", id); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0]  a_tab   [4] = '{16'h1000, 16'h2001, 16'h3002, 16'h4003};
        logic [W-1:0]  b_tab   [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        logic [W-1:0]  exp_sum [4] = '{16'h1011, 16'h2023, 16'h3035, 16'h4047};
        logic [IW-1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [IW-1:0] ids     [5];
        logic [W-1:0]  sums    [5];
        int            at      [5];
        int            n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin ids[k] = '1; sums[k] = '1; at[k] = -100; end
        for (int k = 0; k < N; k++) begin
            req_a[k*W +: W] = a_tab[k];
            req_b[k*W +: W] = b_tab[k];
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        n = 0;
        for (int t = 0; t < 40 && n < 5; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ids[n] = rsp_id; sums[n] = rsp_sum; at[n] = t; n++;
            end
            step();
        end
        req_valid = '0;
        checks++; if (n != 5) begin failures++; $display("FAIL rr_count got=%0d exp=5", n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (ids[i] !== exp_id[i]) begin failures++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", i, ids[i], exp_id[i]); end
            checks++; if (sums[i] !== exp_sum[exp_id[i]]) begin failures++; $display("FAIL rr_sum[%0d] got=%h exp=%h", i, sums[i], exp_sum[exp_id[i]]); end
        end
        for (int i = 1; i < 5; i++) begin
            checks++; if (at[i] - at[i-1] != 3) begin failures++; $display("FAIL rr_spacing[%0d] got=%0d exp=3", i, at[i] - at[i-1]); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  s;
        logic [IW-1:0] id;
        bit            got;
        req_a[15:0] = 16'h0F0F; req_b[15:0] = 16'h1010; req_valid = 4'b0001; rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_accept0 got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        step();
        req_a[31:16] = 16'h0001; req_b[31:16] = 16'h0002; req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=1", c, rsp_valid); end
            checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL bp_rsp_id[%0d] got=%0d exp=0", c, rsp_id); end
            checks++; if (rsp_sum !== 16'h1F1F) begin failures++; $display("FAIL bp_rsp_sum[%0d] got=%h exp=1f1f", c, rsp_sum); end
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_req_ready[%0d] got=%b exp=0000", c, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid_release got=%b exp=1", rsp_valid); end
        step();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_accept1 got=%b exp=0010", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_rsp_valid_after got=%b exp=0", rsp_valid); end
        step();
        req_valid = '0;
        got = 1'b0; s = '1; id = '0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; s = rsp_sum; id = rsp_id; end
            step();
        end
        checks++; if (!got) begin failures++; $display("FAIL bp_req1_timeout got=no_response exp=response"); end
        checks++; if (id !== 2'd1) begin failures++; $display("FAIL bp_req1_id got=%0d exp=1", id); end
        checks++; if (s !== 16'h0003) begin failures++; $display("FAIL bp_req1_sum got=%h exp=0003", s); end
    endtask

    task automatic test_reset_exec();
        logic [W-1:0]  s;
        logic [IW-1:0] id;
        bit            ok;
        bit            got;
        run_one(2, 16'h0100, 16'h0200, s, id, ok);
        checks++; if (!ok || s !== 16'h0300 || id !== 2'd2) begin failures++; $display("FAIL rx_pre got=ok%0d/%h/%0d exp=ok1/0300/2", ok, s, id); end
        req_a[15:0] = 16'h0005; req_b[15:0] = 16'h0006; req_valid = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rx_accept0 got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (add_a !== 16'h0005) begin failures++; $display("FAIL rx_exec_add_a got=%h exp=0005", add_a); end
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rx_no_rsp[%0d] got=%b exp=0", c, rsp_valid); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rx_busy[%0d] got=%b exp=0", c, busy); end
            step();
        end
        req_a[63:48] = 16'h0003; req_b[63:48] = 16'h0004; req_valid = 4'b1100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rx_grant_after_reset got=%b exp=0100", req_ready); end
        step();
        req_valid = '0;
        got = 1'b0; s = '1; id = '0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; s = rsp_sum; id = rsp_id; end
            step();
        end
        checks++; if (!got || id !== 2'd2 || s !== 16'h0300) begin failures++; $display("FAIL rx_req2_rsp got=ok%0d/%0d/%h exp=ok1/2/0300", got, id, s); end
    endtask

    task automatic test_withdrawn();
        int any_rsp;
        int ready3;
        req_a[15:0] = 16'h0007; req_b[15:0] = 16'h0008; req_valid = 4'b0001; rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wd_accept0 got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        step();
        req_a[63:48] = 16'h0009; req_b[63:48] = 16'h0009; req_valid = 4'b1000;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL wd_ready_in_resp got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL wd_rsp_valid got=%b exp=1", rsp_valid); end
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_sum !== 16'h000F || rsp_id !== 2'd0) begin failures++; $display("FAIL wd_rsp got=%h/%0d exp=000f/0", rsp_sum, rsp_id); end
        step();
        any_rsp = 0;
        ready3  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) any_rsp++;
            if (req_ready[3]) ready3++;
            step();
        end
        checks++; if (any_rsp != 0) begin failures++; $display("FAIL wd_spurious_rsp got=%0d exp=0", any_rsp); end
        checks++; if (ready3 != 0) begin failures++; $display("FAIL wd_req3_granted got=%0d exp=0", ready3); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_withdrawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add16_arbiter.md
Name: add16_arbiter

Overview:
- Shares one external combinational 16-bit adder between N_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- Round-robin arbitration picks one requester, drives its latched operands into the shared adder, registers the sum, and returns it on a single tagged response channel.
- Sits between the datapath clients and the single adder instance, so the adder is never duplicated per client.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/sum width; must match the shared adder.
- ID_W, 2, requester-index width; must equal clog2(N_REQ).

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  N_REQ  per-requester request valid.
- i_req_a  in  N_REQ*WIDTH  flattened operand A; requester k uses bits [k*WIDTH +: WIDTH].
- i_req_b  in  N_REQ*WIDTH  flattened operand B, same packing.
- o_req_ready  out  N_REQ  one-hot accept strobe.
- o_add_a  out  WIDTH  operand A to shared adder.
- o_add_b  out  WIDTH  operand B to shared adder.
- i_add_sum  in  WIDTH  sum returned by shared adder (combinational, same cycle).
- o_rsp_valid  out  1  response valid.
- o_rsp_id  out  ID_W  index of the requester that owns the response.
- o_rsp_sum  out  WIDTH  registered sum.
- i_rsp_ready  in  1  response consumer ready.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking/reset: one clock, i_clk; i_reset is synchronous and active-high.
- Reset values: state = IDLE, rr_ptr = 0, operand/sum/id registers = 0.
  - o_req_ready = 0, o_add_a = 0, o_add_b = 0, o_rsp_valid = 0, o_rsp_id = 0, o_rsp_sum = 0, o_busy = 0.
- Three-state FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant = first index k with i_req_valid[k] = 1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - o_req_ready[grant] = 1, combinationally, in the same cycle; all other ready bits = 0.
  - No valid bits set: o_req_ready = 0 and the FSM stays in IDLE.
  - On handshake (valid & ready): latch a, b and grant id; next state EXEC.
  - o_req_ready is never asserted outside IDLE.
- EXEC (exactly 1 cycle):
  - o_add_a / o_add_b driven from the latched registers; they are 0 in every other state.
  - At the clock edge, i_add_sum is captured into o_rsp_sum; next state RESP.
- RESP:
  - o_rsp_valid = 1.
  - o_rsp_id and o_rsp_sum are held stable until i_rsp_ready = 1.
  - On handshake: rr_ptr <= (id + 1) mod N_REQ; next state IDLE.
  - Backpressure: the FSM stays in RESP indefinitely; no new request is accepted.
- Latency and throughput:
  - Request acceptance to o_rsp_valid rising = 2 cycles.
  - With i_rsp_ready held at 1: one transaction per 3 cycles.
- Arithmetic:
  - Sum is taken from the shared adder, modulo 2^WIDTH.
  - No carry-out; overflow wraps silently (0xFFFF + 0x0001 = 0x0000).
- Fairness:
  - A continuously-valid requester is granted within N_REQ transactions.
  - The pointer advances only on a completed response, not on grant.
- Requester rules:
  - A requester must hold valid and operands stable until ready.
  - Deasserting valid before ready is legal; no request is taken.
  - Operands changing after acceptance have no effect.
- Simultaneous events: multiple valid bits are resolved by round-robin only. Priority does not depend on index beyond rr_ptr order.
- Reset mid-operation (EXEC or RESP): the transaction is discarded and no response is issued. All registers, including rr_ptr, return to reset values on the next edge.
- o_rsp_valid never falls without a handshake, except by reset.

Test Plan:
- Reset then single request: req 0, a=0x1234, b=0x0101 at cycle 0.
  - o_req_ready[0] = 1 at cycle 0.
  - o_add_a = 0x1234 at cycle 1.
  - o_rsp_valid = 1, o_rsp_id = 0, o_rsp_sum = 0x1335 at cycle 2.
  - o_busy falls after the handshake.
- Wrap-around: a=0xFFFF, b=0x0001 -> o_rsp_sum = 0x0000; a=0x8000, b=0x8000 -> 0x0000.
- Round-robin: all four valid continuously, rsp_ready = 1.
  - Grants follow ids 0, 1, 2, 3, 0.
  - Each response arrives 3 cycles after the previous one.
  - Each returns that requester's own sum.
- Backpressure: i_rsp_ready = 0 for 5 cycles during RESP.
  - o_rsp_sum and o_rsp_id stay stable.
  - o_req_ready = 0 throughout, while req 1 is valid.
  - Req 1 is accepted the cycle after the response handshake.
- Reset in EXEC: assert i_reset during EXEC.
  - No response is issued; o_rsp_valid stays 0; rr_ptr = 0.
  - With reqs 2 and 3 both valid next, req 2 is granted first.
- Withdrawn request: req 3 is valid for 1 cycle while the FSM is in RESP, then deasserts.
  - Req 3 is never granted and no response with id 3 appears.
